// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory load/store unit.
// Access sizes, FSM states and default memory map.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] DEFAULT_BASE  = 32'h1001_0000;
  localparam int          DEFAULT_DEPTH = 1024;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCESS    = 3'd1,
    RMW_READ  = 3'd2,
    RMW_WRITE = 3'd3,
    RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/mem_access_unit_lane.sv
// Little-endian byte/halfword lane extract and merge.
// Purely combinational; shared by load and RMW paths.
module byte_lane_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            offset,
  input  logic [1:0]            size,
  input  logic                  zero_ext,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] store_word
);

  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [DATA_WIDTH-1:0] BYTE_MASK =
    {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
  localparam logic [DATA_WIDTH-1:0] HALF_MASK =
    {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};

  logic [SW-1:0]         sh;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;

  assign sh      = SW'({offset, 3'b000});
  assign shifted = word >> sh;

  always_comb begin
    load_data = word;
    mask      = '1;
    unique case (size)
      SIZE_BYTE: begin
        load_data = zero_ext
          ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
          : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
        mask = BYTE_MASK << sh;
      end
      SIZE_HALF: begin
        load_data = zero_ext
          ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
          : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
        mask = HALF_MASK << sh;
      end
      default: begin
        load_data = word;
        mask      = '1;
      end
    endcase
  end

  assign store_word = (word & ~mask) | ((wdata << sh) & mask);

endmodule

// File: rtl/mem_access_unit.sv
// Core-side load/store unit for a word-wide data memory.
// Sub-word stores are read-modify-write; bad requests trap early.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int                  DATA_WIDTH   = 32,
  parameter int                  MEMORY_DEPTH = DEFAULT_DEPTH,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DEFAULT_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [DATA_WIDTH:0] LO =
    (DATA_WIDTH+1)'(BASE_ADDRESS);
  localparam logic [DATA_WIDTH:0] HI =
    LO + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, merge_q, rdata_q;
  logic [1:0]            size_q;
  logic                  write_q, uns_q, err_q;

  logic                  req_err;
  logic                  in_range;
  logic [DATA_WIDTH:0]   addr_ext;
  logic [DATA_WIDTH-1:0] aligned;
  logic [DATA_WIDTH-1:0] lane_word;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  assign addr_ext = {1'b0, req_addr};
  assign in_range = (addr_ext >= LO) && (addr_ext < HI);

  always_comb begin
    req_err = !in_range;
    unique case (req_size)
      SIZE_BYTE: ;
      SIZE_HALF: if (req_addr[0]) req_err = 1'b1;
      SIZE_WORD: if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      default:   req_err = 1'b1;
    endcase
  end

  assign aligned = {addr_q[DATA_WIDTH-1:2], 2'b00};

  byte_lane_unit #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .word       (lane_word),
    .offset     (addr_q[1:0]),
    .size       (size_q),
    .zero_ext   (uns_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    lane_word      = mem_read_data;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)
            state_d = RESP;
          else if (req_write && req_size != SIZE_WORD)
            state_d = RMW_READ;
          else
            state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_address = aligned;
        if (write_q) begin
          mem_write      = 1'b1;
          mem_write_data = wdata_q;
        end else begin
          mem_read = 1'b1;
        end
        state_d = RESP;
      end
      RMW_READ: begin
        mem_address = aligned;
        mem_read    = 1'b1;
        state_d     = RMW_WRITE;
      end
      RMW_WRITE: begin
        mem_address    = aligned;
        mem_write      = 1'b1;
        lane_word      = merge_q;
        mem_write_data = store_word;
        state_d        = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      size_q  <= SIZE_BYTE;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        write_q <= req_write;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state_q == ACCESS && !write_q)
        rdata_q <= load_data;
      if (state_q == RMW_READ)
        merge_q <= mem_read_data;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_error = (state_q == RESP) && err_q;
  assign resp_rdata = (state_q == RESP) ? rdata_q : '0;

endmodule
